yarp_mem_arbiter: RTL and testbench

Shares one external memory bus between the YARP core's instruction-fetch port and data-memory port. Each core port issues a request that is held until completion. The arbiter serialises the requests onto a single bus with a request/grant/response handshake, allows one outstanding transaction, alternates priority on contention, and bounds response waits with a timeout. It sits between the core's instr/data memory interfaces and the system memory.

---
 rtl/yarp_mem_arbiter_if.sv | 47 ++++
 rtl/yarp_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_mem_arbiter_if.sv
// Signal bundle between yarp_mem_arbiter, the core's instr/data ports and the memory bus.
// The _i/_o suffixes are from the arbiter's point of view.
interface yarp_mem_arbiter_if;
  logic        imem_req_i;
  logic [31:0] imem_addr_i;
  logic        imem_ready_o;
  logic [31:0] imem_rd_data_o;

  logic        dmem_req_i;
  logic [31:0] dmem_addr_i;
  logic        dmem_wr_i;
  logic [1:0]  dmem_byte_en_i;
  logic [31:0] dmem_wr_data_i;
  logic        dmem_ready_o;
  logic [31:0] dmem_rd_data_o;

  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_wr_o;
  logic [1:0]  bus_byte_en_o;
  logic [31:0] bus_wr_data_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rd_data_i;

  logic        err_o;

  modport slave (
    input  imem_req_i, imem_addr_i,
    input  dmem_req_i, dmem_addr_i, dmem_wr_i, dmem_byte_en_i, dmem_wr_data_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rd_data_i,
    output imem_ready_o, imem_rd_data_o,
    output dmem_ready_o, dmem_rd_data_o,
    output bus_req_o, bus_addr_o, bus_wr_o, bus_byte_en_o, bus_wr_data_o,
    output err_o
  );

  modport master (
    output imem_req_i, imem_addr_i,
    output dmem_req_i, dmem_addr_i, dmem_wr_i, dmem_byte_en_i, dmem_wr_data_i,
    output bus_gnt_i, bus_rvalid_i, bus_rd_data_i,
    input  imem_ready_o, imem_rd_data_o,
    input  dmem_ready_o, dmem_rd_data_o,
    input  bus_req_o, bus_addr_o, bus_wr_o, bus_byte_en_o, bus_wr_data_o,
    input  err_o
  );
endinterface

// File: rtl/yarp_mem_arbiter.sv
// Serialises YARP instruction-fetch and data accesses onto one memory bus,
// one outstanding transaction at a time, with alternating tie priority and a response timeout.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner's payload
// REQ    | bus_req_o high with latched payload, waiting for bus_gnt_i
// RESP   | granted, waiting for bus_rvalid_i or the timeout
// DONE   | owner's ready pulse (with err_o on timeout), then back to IDLE
module yarp_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  yarp_mem_arbiter_if.slave mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [1:0]  byte_en_q, byte_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] imem_rd_q, imem_rd_d;
  logic [31:0] dmem_rd_q, dmem_rd_d;

  logic        any_req;
  logic        pick_data;
  logic [31:0] cnt_inc;
  logic        timeout_hit;

  assign any_req     = mem.imem_req_i | mem.dmem_req_i;
  // On a tie the port that did not win the previous arbitration takes the bus.
  assign pick_data   = mem.dmem_req_i & (~mem.imem_req_i | (last_owner_q == OWN_INSTR));
  assign cnt_inc     = cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INSTR;
      last_owner_q <= OWN_INSTR;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      byte_en_q    <= 2'b00;
      wr_data_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      imem_rd_q    <= '0;
      dmem_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      byte_en_q    <= byte_en_d;
      wr_data_q    <= wr_data_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      imem_rd_q    <= imem_rd_d;
      dmem_rd_q    <= dmem_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    byte_en_d    = byte_en_q;
    wr_data_d    = wr_data_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    imem_rd_d    = imem_rd_q;
    dmem_rd_d    = dmem_rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_REQ;
          err_d   = 1'b0;
          if (pick_data) begin
            owner_d      = OWN_DATA;
            last_owner_d = OWN_DATA;
            addr_d       = mem.dmem_addr_i;
            wr_d         = mem.dmem_wr_i;
            byte_en_d    = mem.dmem_byte_en_i;
            wr_data_d    = mem.dmem_wr_data_i;
          end else begin
            owner_d      = OWN_INSTR;
            last_owner_d = OWN_INSTR;
            addr_d       = mem.imem_addr_i;
            wr_d         = 1'b0;
            byte_en_d    = 2'b10;
            wr_data_d    = '0;
          end
        end
      end

      S_REQ: begin
        if (mem.bus_gnt_i) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end

      S_RESP: begin
        // A response landing on the timeout cycle still completes normally.
        if (mem.bus_rvalid_i) begin
          state_d = S_DONE;
          if (owner_q == OWN_DATA) begin
            dmem_rd_d = mem.bus_rd_data_i;
          end else begin
            imem_rd_d = mem.bus_rd_data_i;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (owner_q == OWN_DATA) begin
              dmem_rd_d = '0;
            end else begin
              imem_rd_d = '0;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem.bus_req_o      = (state_q == S_REQ);
  assign mem.bus_addr_o     = addr_q;
  assign mem.bus_wr_o       = wr_q;
  assign mem.bus_byte_en_o  = byte_en_q;
  assign mem.bus_wr_data_o  = wr_data_q;

  assign mem.imem_ready_o   = (state_q == S_DONE) && (owner_q == OWN_INSTR);
  assign mem.dmem_ready_o   = (state_q == S_DONE) && (owner_q == OWN_DATA);
  assign mem.imem_rd_data_o = imem_rd_q;
  assign mem.dmem_rd_data_o = dmem_rd_q;
  assign mem.err_o          = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Scoreboard bench for yarp_mem_arbiter: a bus responder model predicts each completion,
// a monitor pops and compares on every ready pulse.
module tb_yarp_mem_arbiter;
  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  yarp_mem_arbiter_if mif();

  yarp_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as the DUT sampled them at the most recent rising edge
  logic        s_rst = 1'b1;
  logic        s_ireq = 1'b0, s_dreq = 1'b0, s_dwr = 1'b0;
  logic [31:0] s_iaddr = '0, s_daddr = '0, s_dwd = '0;
  logic [1:0]  s_dbe = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_rst   <= reset;
    s_ireq  <= mif.imem_req_i;
    s_iaddr <= mif.imem_addr_i;
    s_dreq  <= mif.dmem_req_i;
    s_daddr <= mif.dmem_addr_i;
    s_dwr   <= mif.dmem_wr_i;
    s_dbe   <= mif.dmem_byte_en_i;
    s_dwd   <= mif.dmem_wr_data_i;
  end

  typedef struct {
    logic        port;   // 1 = data port
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  logic rlog[$];
  int   fq_gd[$];
  int   fq_rd[$];
  logic [31:0] fq_data[$];

  // ---------------- bus responder / reference model ----------------
  int          r_rs = 0, r_k = 0, r_gd = 0, r_rd = 0, r_rcnt = 0, r_reqcyc = 0;
  logic        r_own = 1'b0, m_last = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, r_data = '0;
  logic        e_wr = 1'b0;
  logic [1:0]  e_be = '0;
  exp_t        r_e;

  task automatic check_payload(input string tag);
    check({tag, " bus_addr"}, mif.bus_addr_o, e_addr);
    check({tag, " bus_wr"}, 32'(mif.bus_wr_o), 32'(e_wr));
    check({tag, " bus_byte_en"}, 32'(mif.bus_byte_en_o), 32'(e_be));
    check({tag, " bus_wr_data"}, mif.bus_wr_data_o, e_wd);
  endtask

  task automatic resp_step();
    mif.bus_rvalid_i = 1'b0;
    if ((r_rd + 1) <= int'(TMO) && r_rcnt == r_rd + 1) begin
      if (fq_data.size() > 0) r_data = fq_data.pop_front();
      else r_data = $urandom;
      mif.bus_rvalid_i  = 1'b1;
      mif.bus_rd_data_i = r_data;
      r_e.port = r_own; r_e.data = r_data; r_e.err = 1'b0; r_e.cyc = cyc + 1;
      sb.push_back(r_e);
      r_rs = 3;
    end else if (r_rcnt == int'(TMO)) begin
      r_e.port = r_own; r_e.data = 32'd0; r_e.err = 1'b1; r_e.cyc = cyc + 1;
      sb.push_back(r_e);
      r_rs = 3;
    end
  endtask

  initial begin : responder
    mif.bus_gnt_i = 1'b0;
    mif.bus_rvalid_i = 1'b0;
    mif.bus_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (s_rst) begin
        if (r_rs != 0) check("bus_req after reset", 32'(mif.bus_req_o), 32'd0);
        r_rs = 0;
        m_last = 1'b0;
        mif.bus_gnt_i = 1'b0;
        mif.bus_rvalid_i = 1'b0;
      end else begin
        case (r_rs)
          0: begin
            if (mif.bus_req_o) begin
              if (!s_ireq && !s_dreq) begin
                check("bus_req without request", 32'(mif.bus_req_o), 32'd0);
              end else begin
                if (s_ireq && s_dreq) r_own = ~m_last;
                else r_own = s_dreq;
                m_last = r_own;
                e_addr = r_own ? s_daddr : s_iaddr;
                e_wr   = r_own ? s_dwr : 1'b0;
                e_be   = r_own ? s_dbe : 2'b10;
                e_wd   = r_own ? s_dwd : 32'd0;
                check_payload("req");
                r_gd = (fq_gd.size() > 0) ? fq_gd.pop_front() : int'($urandom_range(3, 0));
                r_rd = (fq_rd.size() > 0) ? fq_rd.pop_front() : int'($urandom_range(5, 0));
                r_k = 0;
                r_reqcyc = 1;
                r_rs = 1;
                mif.bus_gnt_i = (r_gd == 0);
                mif.bus_rvalid_i = 1'b0;
              end
            end else begin
              // stray handshakes outside REQ/RESP must be ignored
              mif.bus_gnt_i = ($urandom_range(3, 0) == 0);
              mif.bus_rvalid_i = ($urandom_range(3, 0) == 0);
              mif.bus_rd_data_i = $urandom;
            end
          end
          1: begin
            if (mif.bus_gnt_i) begin
              mif.bus_gnt_i = 1'b0;
              check("bus_req low in RESP", 32'(mif.bus_req_o), 32'd0);
              r_rcnt = 1;
              r_rs = 2;
              resp_step();
            end else begin
              check("bus_req held in REQ", 32'(mif.bus_req_o), 32'd1);
              if (mif.bus_req_o) r_reqcyc++;
              check_payload("stable");
              r_k++;
              mif.bus_gnt_i = (r_k == r_gd);
              mif.bus_rvalid_i = ($urandom_range(3, 0) == 0);
              mif.bus_rd_data_i = $urandom;
            end
          end
          2: begin
            r_rcnt++;
            check("bus_req low in RESP", 32'(mif.bus_req_o), 32'd0);
            check("bus_addr held in RESP", mif.bus_addr_o, e_addr);
            resp_step();
          end
          default: begin
            mif.bus_rvalid_i = ($urandom_range(1, 0) == 0);
            mif.bus_gnt_i = ($urandom_range(1, 0) == 0);
            mif.bus_rd_data_i = $urandom;
            r_rs = 0;
          end
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] m_ird = '0, m_drd = '0;
  logic        prev_rdy = 1'b0;
  exp_t        m_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (s_rst) begin
        sb.delete();
        m_ird = '0;
        m_drd = '0;
        prev_rdy = 1'b0;
      end else begin
        if (prev_rdy) check("no re-grant after ready", 32'(mif.bus_req_o), 32'd0);
        if (mif.imem_ready_o || mif.dmem_ready_o) begin
          check("ready exclusive", 32'(mif.imem_ready_o & mif.dmem_ready_o), 32'd0);
          rlog.push_back(mif.dmem_ready_o);
          if (sb.size() == 0) begin
            check("unexpected ready", 32'({mif.imem_ready_o, mif.dmem_ready_o}), 32'd0);
          end else begin
            m_e = sb.pop_front();
            check("ready port", 32'(mif.dmem_ready_o), 32'(m_e.port));
            check("ready cycle", 32'(cyc), 32'(m_e.cyc));
            check("err_o with ready", 32'(mif.err_o), 32'(m_e.err));
            if (m_e.port) m_drd = m_e.data;
            else m_ird = m_e.data;
          end
        end else begin
          check("err_o without ready", 32'(mif.err_o), 32'd0);
        end
        check("imem_rd_data", mif.imem_rd_data_o, m_ird);
        check("dmem_rd_data", mif.dmem_rd_data_o, m_drd);
        prev_rdy = mif.imem_ready_o | mif.dmem_ready_o;
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic issue_i(input logic [31:0] addr, input bit hold, output int rc);
    mif.imem_addr_i = addr;
    mif.imem_req_i  = 1'b1;
    rc = -1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (mif.imem_ready_o) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) check("imem ready timeout", 32'(mif.imem_ready_o), 32'd1);
    if (!hold) mif.imem_req_i = 1'b0;
  endtask

  task automatic issue_d(input logic [31:0] addr, input logic wr, input logic [1:0] be,
                         input logic [31:0] wd, input bit hold, output int rc);
    mif.dmem_addr_i    = addr;
    mif.dmem_wr_i      = wr;
    mif.dmem_byte_en_i = be;
    mif.dmem_wr_data_i = wd;
    mif.dmem_req_i     = 1'b1;
    rc = -1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (mif.dmem_ready_o) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) check("dmem ready timeout", 32'(mif.dmem_ready_o), 32'd1);
    if (!hold) mif.dmem_req_i = 1'b0;
  endtask

  task automatic run_i(input int n);
    int rc, gap;
    bit hold;
    for (int t = 0; t < n; t++) begin
      gap  = $urandom_range(3, 0);
      hold = (gap == 0) && (t != n - 1);
      issue_i($urandom & 32'hFFFF_FFFC, hold, rc);
      if (!hold) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_d(input int n);
    int rc, gap;
    bit hold;
    for (int t = 0; t < n; t++) begin
      gap  = $urandom_range(3, 0);
      hold = (gap == 0) && (t != n - 1);
      issue_d($urandom, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom, hold, rc);
      if (!hold) repeat (gap) @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  int c0, rc, rc2;
  bit seen;

  initial begin : main
    mif.imem_req_i = 1'b0; mif.imem_addr_i = '0;
    mif.dmem_req_i = 1'b0; mif.dmem_addr_i = '0; mif.dmem_wr_i = 1'b0;
    mif.dmem_byte_en_i = '0; mif.dmem_wr_data_i = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset bus_req", 32'(mif.bus_req_o), 32'd0);
    check("reset bus_wr", 32'(mif.bus_wr_o), 32'd0);
    check("reset bus_addr", mif.bus_addr_o, 32'd0);
    check("reset bus_wr_data", mif.bus_wr_data_o, 32'd0);
    check("reset bus_byte_en", 32'(mif.bus_byte_en_o), 32'd0);
    check("reset readies", 32'({mif.imem_ready_o, mif.dmem_ready_o, mif.err_o}), 32'd0);
    check("reset imem_rd_data", mif.imem_rd_data_o, 32'd0);
    check("reset dmem_rd_data", mif.dmem_rd_data_o, 32'd0);
    reset = 1'b0;

    // contention straight out of reset: D, I, D, I
    rlog.delete();
    fork
      begin issue_d(32'h2000, 1'b0, 2'b10, 32'd0, 1'b1, rc); issue_d(32'h2004, 1'b0, 2'b10, 32'd0, 1'b0, rc); end
      begin issue_i(32'h1004, 1'b1, rc2); issue_i(32'h1008, 1'b0, rc2); end
    join
    check("contention grants", 32'(rlog.size()), 32'd4);
    if (rlog.size() == 4) begin
      check("contention order 0", 32'(rlog[0]), 32'd1);
      check("contention order 1", 32'(rlog[1]), 32'd0);
      check("contention order 2", 32'(rlog[2]), 32'd1);
      check("contention order 3", 32'(rlog[3]), 32'd0);
    end

    // single fetch, zero wait states
    @(negedge clk);
    fq_gd.push_back(0); fq_rd.push_back(0); fq_data.push_back(32'h0050_0093);
    c0 = cyc;
    issue_i(32'h1000, 1'b0, rc);
    check("fetch latency", 32'(rc - c0), 32'd3);
    check("fetch data", mif.imem_rd_data_o, 32'h0050_0093);
    check("fetch bus_addr", mif.bus_addr_o, 32'h1000);
    check("fetch bus_wr", 32'(mif.bus_wr_o), 32'd0);

    // store with grant delayed five cycles
    @(negedge clk);
    fq_gd.push_back(5); fq_rd.push_back(1); fq_data.push_back(32'h1234_5678);
    issue_d(32'h3000, 1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0, rc);
    check("store REQ cycles", 32'(r_reqcyc), 32'd6);

    // timeout, then rvalid on the timeout cycle itself
    @(negedge clk);
    fq_gd.push_back(0); fq_rd.push_back(5);
    c0 = cyc;
    issue_d(32'h3004, 1'b0, 2'b10, 32'd0, 1'b0, rc);
    check("timeout latency", 32'(rc - c0), 32'(TMO + 2));
    check("timeout rd_data", mif.dmem_rd_data_o, 32'd0);
    @(negedge clk);
    fq_gd.push_back(0); fq_rd.push_back(int'(TMO) - 1); fq_data.push_back(32'hCAFE_F00D);
    c0 = cyc;
    issue_d(32'h3008, 1'b0, 2'b01, 32'd0, 1'b0, rc);
    check("late rvalid latency", 32'(rc - c0), 32'(TMO + 2));
    check("late rvalid data", mif.dmem_rd_data_o, 32'hCAFE_F00D);

    // reset while waiting for the response
    @(negedge clk);
    fq_gd.push_back(0); fq_rd.push_back(5);
    mif.dmem_addr_i = 32'h4000; mif.dmem_wr_i = 1'b0; mif.dmem_req_i = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      @(negedge clk);
      seen = mif.bus_req_o;
    end
    check("reset test reached REQ", 32'(seen), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    mif.dmem_req_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("bus_req after mid-RESP reset", 32'(mif.bus_req_o), 32'd0);
    repeat (8) @(negedge clk);
    check("no ready after reset", 32'({mif.imem_ready_o, mif.dmem_ready_o}), 32'd0);

    // first tie after reset goes to data again
    rlog.delete();
    fork
      issue_d(32'h5000, 1'b0, 2'b10, 32'd0, 1'b0, rc);
      issue_i(32'h1010, 1'b0, rc2);
    join
    check("post-reset tie size", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2) begin
      check("post-reset tie first", 32'(rlog[0]), 32'd1);
      check("post-reset tie second", 32'(rlog[1]), 32'd0);
    end

    // held fetch request: re-arbitrated only after DONE
    @(negedge clk);
    fq_gd.push_back(0); fq_rd.push_back(0);
    fq_gd.push_back(0); fq_rd.push_back(0);
    issue_i(32'h1100, 1'b1, rc);
    issue_i(32'h1104, 1'b0, rc2);
    check("back-to-back interval", 32'(rc2 - rc), 32'd4);

    // randomized concurrent traffic
    @(negedge clk);
    fork
      run_i(40);
      run_d(40);
    join
    repeat (10) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
